soc_design_pio_poller: RTL and testbench

Avalon-MM host that periodically reads one register of a read-only PIO agent and turns value changes into a buffered event stream. It sits on the FPGA-fabric side of the SoC interconnect, in front of input-PIO agents (8-bit data, registered readdata, read latency 1, no waitrequest). It frees software from busy-polling: each change of the sampled bits becomes one FIFO entry with rise/fall masks, and a sticky overflow flag reports lost changes.

---
 rtl/soc_design_pio_poller.sv | 137 +++++++++++++
 tb/tb_soc_design_pio_poller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_design_pio_poller.sv
// Avalon-MM host that polls one read-only PIO register and turns value changes
// into a first-word-fall-through event FIFO with rise/fall masks and sticky overflow.
module soc_design_pio_poller #(
    parameter int POLL_PERIOD  = 1000,
    parameter int POLL_ADDR    = 0,
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [DATA_W-1:0] evt_rise,
    output logic [DATA_W-1:0] evt_fall,
    output logic [DATA_W-1:0] current_value,
    output logic              overflow,
    input  logic              ovf_clr
);

    // state | meaning
    // IDLE  | timer counts poll interval while enabled
    // REQ   | avm_read high until the agent accepts
    // WAIT  | read latency elapses, sample captured on last cycle
    // CMP   | compare sample with current_value, push event on change
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CMP} state_t;

    localparam int TW = $clog2(POLL_PERIOD + 1);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 3 * DATA_W;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer;
    logic [LW-1:0]     lat_cnt;
    logic [DATA_W-1:0] sample;
    logic              baseline_valid;
    logic              timer_tc, lat_last;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, pop, push_req, push_ok, drop;
    logic [EW-1:0]     push_entry;

    // Upper readdata bits are intentionally ignored.
    logic unused_hi;
    assign unused_hi = ^avm_readdata;

    assign avm_address = ADDR_W'(POLL_ADDR);
    assign avm_read    = (state == S_REQ);
    assign timer_tc    = (timer == TW'(POLL_PERIOD - 1));
    assign lat_last    = (lat_cnt == LW'(READ_LATENCY - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable && timer_tc) state_nxt = S_REQ;
            S_REQ:   if (!avm_waitrequest) state_nxt = S_WAIT;
            S_WAIT:  if (lat_last) state_nxt = S_CMP;
            S_CMP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            timer          <= '0;
            lat_cnt        <= '0;
            sample         <= '0;
            current_value  <= '0;
            baseline_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && enable && !timer_tc)
                timer <= timer + 1'b1;
            else
                timer <= '0;
            if (state == S_WAIT)
                lat_cnt <= lat_cnt + 1'b1;
            else
                lat_cnt <= '0;
            if (state == S_WAIT && lat_last)
                sample <= avm_readdata[DATA_W-1:0];
            if (state == S_CMP) begin
                current_value  <= sample;
                baseline_valid <= 1'b1;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign full       = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop        = evt_valid && evt_ready;
    assign push_req   = (state == S_CMP) && baseline_valid && (sample != current_value);
    assign push_ok    = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign push_entry = {sample, sample & ~current_value, ~sample & current_value};

    assign evt_valid = (count != '0);
    assign {evt_data, evt_rise, evt_fall} = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_soc_design_pio_poller.sv
// Directed self-checking bench for soc_design_pio_poller with a constant-value
// PIO agent model (period 4, latency 1, depth 4).
module tb_soc_design_pio_poller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_data, evt_rise, evt_fall, current_value;
    logic        overflow;
    logic        ovf_clr;

    logic [7:0]  agent;
    int          checks = 0;
    int          failures = 0;
    logic        seen_valid;

    assign avm_readdata = {24'hABCDEF, agent};

    soc_design_pio_poller #(
        .POLL_PERIOD(4), .POLL_ADDR(0), .ADDR_W(2), .DATA_W(8),
        .READ_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .evt_rise(evt_rise), .evt_fall(evt_fall),
        .current_value(current_value), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        seen_valid = seen_valid | evt_valid;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks until the next rising avm_read; n is the number of cycles elapsed.
    task automatic wait_rise(output int n);
        n = 0;
        while (avm_read === 1'b1 && n < 100) begin tick(); n++; end
        while (avm_read !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) check("wait_rise_timeout", 32'(n), 32'd0);
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic [7:0] r,
                              input logic [7:0] f);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_data"},  32'(evt_data),  32'(d));
        check({tag, "_rise"},  32'(evt_rise),  32'(r));
        check({tag, "_fall"},  32'(evt_fall),  32'(f));
    endtask

    initial begin
        int n, m;
        logic read_seen;
        reset = 1'b1; enable = 1'b0; avm_waitrequest = 1'b0;
        evt_ready = 1'b0; ovf_clr = 1'b0; agent = 8'h5A; seen_valid = 1'b0;
        tick(); tick();

        check("rst_read",     32'(avm_read),      32'd0);
        check("rst_addr",     32'(avm_address),   32'd0);
        check("rst_valid",    32'(evt_valid),     32'd0);
        check("rst_data",     32'(evt_data),      32'd0);
        check("rst_rise",     32'(evt_rise),      32'd0);
        check("rst_fall",     32'(evt_fall),      32'd0);
        check("rst_current",  32'(current_value), 32'd0);
        check("rst_overflow", 32'(overflow),      32'd0);

        // Baseline with constant 0x5A
        reset = 1'b0; enable = 1'b1; seen_valid = 1'b0;
        wait_rise(n);
        check("first_poll_delay", 32'(n), 32'd4);
        check("addr_at_read", 32'(avm_address), 32'd0);
        wait_rise(n);
        check("period_1", 32'(n), 32'd7);
        check("baseline_current", 32'(current_value), 32'h5A);
        wait_rise(n);
        check("period_2", 32'(n), 32'd7);
        check("baseline_no_event", 32'(seen_valid), 32'd0);

        // Change 0x5A -> 0x0F, then 0x0F -> 0xF0; evt_valid at t+3
        agent = 8'h0F;
        tick(); tick();
        check("evt_not_yet_t2", 32'(evt_valid), 32'd0);
        tick();
        check_head("chg_0f", 8'h0F, 8'h05, 8'h50);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check("pop_empty", 32'(evt_valid), 32'd0);
        agent = 8'hF0;
        wait_rise(n);
        tick(); tick();
        check("evt_not_yet_t2b", 32'(evt_valid), 32'd0);
        tick();
        check_head("chg_f0", 8'hF0, 8'hF0, 8'h0F);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check("pop_empty2", 32'(evt_valid), 32'd0);

        // Stall for 3 REQ cycles
        wait_rise(n);
        agent = 8'h3C; avm_waitrequest = 1'b1; n = 0;
        repeat (3) begin
            check("stall_read", 32'(avm_read), 32'd1);
            check("stall_addr", 32'(avm_address), 32'd0);
            tick(); n++;
        end
        avm_waitrequest = 1'b0;
        check("stall_read_accept", 32'(avm_read), 32'd1);
        wait_rise(m);
        check("stall_period", 32'(n + m), 32'd10);
        check_head("stall_evt", 8'h3C, 8'h0C, 8'hC0);
        check("stall_current", 32'(current_value), 32'h3C);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check("pop_empty3", 32'(evt_valid), 32'd0);

        // Overflow: five changes into a depth-4 FIFO with no consumer
        for (int v = 1; v <= 5; v++) begin
            wait_rise(n);
            agent = 8'(v);
        end
        tick(); tick(); tick();
        check("ovf_set", 32'(overflow), 32'd1);
        wait_rise(n);
        agent = 8'h06;
        tick(); tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        check_head("ovf_e1", 8'h01, 8'h01, 8'h3C); tick();
        check_head("ovf_e2", 8'h02, 8'h02, 8'h01); tick();
        check_head("ovf_e3", 8'h03, 8'h01, 8'h00); tick();
        check_head("ovf_e4", 8'h04, 8'h04, 8'h03); tick();
        evt_ready = 1'b0;
        check("ovf_drained", 32'(evt_valid), 32'd0);

        // Full FIFO with simultaneous pop accepts the push
        for (int v = 7; v <= 10; v++) begin
            wait_rise(n);
            agent = 8'(v);
        end
        wait_rise(n);
        agent = 8'h0B;
        tick(); tick();
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check("full_pop_no_ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        check("full_pop_e8", 32'(evt_data), 32'h08); tick();
        check("full_pop_e9", 32'(evt_data), 32'h09); tick();
        check("full_pop_e10", 32'(evt_data), 32'h0A); tick();
        evt_ready = 1'b0;
        check_head("full_pop_e11", 8'h0B, 8'h01, 8'h00);

        // Reset during WAIT
        wait_rise(n);
        agent = 8'h22;
        tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_read", 32'(avm_read), 32'd0);
        check("midrst_fifo_empty", 32'(evt_valid), 32'd0);
        check("midrst_current", 32'(current_value), 32'd0);
        tick();
        reset = 1'b0;
        wait_rise(n);
        check("post_rst_delay", 32'(n), 32'd4);
        tick(); tick(); tick();
        check("post_rst_baseline_no_evt", 32'(evt_valid), 32'd0);
        check("post_rst_current", 32'(current_value), 32'h22);

        // Enable dropped in REQ: read completes, then no more polls
        wait_rise(n);
        agent = 8'h99; enable = 1'b0;
        tick(); tick(); tick();
        check_head("en_drop_evt", 8'h99, 8'h99, 8'h22);
        read_seen = 1'b0;
        repeat (20) begin tick(); read_seen = read_seen | avm_read; end
        check("en_drop_no_read", 32'(read_seen), 32'd0);
        enable = 1'b1;
        wait_rise(n);
        check("reenable_delay", 32'(n), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
